// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered 2:1 mux channel.
// Bursts are capped at MAX_HOLD beats whenever the other side is waiting.
module mux2_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s0,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             last_b, last_b_nxt;
    logic             beat;
    logic             req_own, req_oth;
    state_t           other;
    logic [WIDTH-1:0] din_sel;

    assign req_own = (state == GNT_B) ? req_b : req_a;
    assign req_oth = (state == GNT_B) ? req_a : req_b;
    assign other   = (state == GNT_B) ? GNT_A : GNT_B;
    assign din_sel = (state == GNT_B) ? din_b : din_a;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_b_nxt   = last_b;
        beat         = 1'b0;
        case (state)
            IDLE: begin
                hold_cnt_nxt = '0;
                // On a tie, the side that was not served last wins.
                if (req_a && (!req_b || last_b)) begin
                    state_nxt = GNT_A;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (req_own) begin
                    beat = 1'b1;
                    if ((hold_cnt == HOLD_LAST) && req_oth) begin
                        state_nxt    = other;
                        hold_cnt_nxt = '0;
                        last_b_nxt   = (state == GNT_B);
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end else begin
                    state_nxt    = req_oth ? other : IDLE;
                    hold_cnt_nxt = '0;
                    last_b_nxt   = (state == GNT_B);
                end
            end
            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // Grant outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_b   <= 1'b1;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            s0       <= 1'b0;
            y        <= '0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last_b   <= last_b_nxt;
            gnt_a    <= (state_nxt == GNT_A);
            gnt_b    <= (state_nxt == GNT_B);
            s0       <= (state_nxt == GNT_B);
            y_valid  <= beat;
            if (beat) begin
                y <= din_sel;
            end
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: a queue-based ownership model predicts
// every cycle's grant/data outputs, and a monitor compares them on the falling edge.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int MH    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a, req_b;
    logic [WIDTH-1:0] din_a, din_b;
    logic             gnt_a, gnt_b, s0, y_valid;
    logic [WIDTH-1:0] y;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .din_a   (din_a),
        .din_b   (din_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .s0      (s0),
        .y       (y),
        .y_valid (y_valid)
    );

    typedef struct packed {
        logic             ga;
        logic             gb;
        logic             s;
        logic             yv;
        logic [WIDTH-1:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B; beats = beats in current grant.
    int             m_owner, m_beats, m_last;
    logic [WIDTH-1:0] m_y;
    logic           m_yv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_beats = 0;
        m_last  = 2;
        m_y     = '0;
        m_yv    = 1'b0;
    endtask

    task automatic model_step(input logic ra, input logic rb,
                              input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        logic             req [3];
        logic [WIDTH-1:0] d   [3];
        int               x, o;
        req[0] = 1'b0; req[1] = ra; req[2] = rb;
        d[0]   = '0;   d[1]   = da; d[2]   = db;
        if (m_owner == 0) begin
            m_yv    = 1'b0;
            m_beats = 0;
            if (req[1] && req[2]) m_owner = 3 - m_last;
            else if (req[1])      m_owner = 1;
            else if (req[2])      m_owner = 2;
        end else begin
            x = m_owner;
            o = 3 - x;
            if (req[x]) begin
                m_yv = 1'b1;
                m_y  = d[x];
                m_beats++;
                if (m_beats >= MH && req[o]) begin
                    m_owner = o;
                    m_last  = x;
                    m_beats = 0;
                end
            end else begin
                m_yv    = 1'b0;
                m_last  = x;
                m_beats = 0;
                m_owner = req[o] ? o : 0;
            end
        end
    endtask

    task automatic cycle(input logic ra, input logic rb,
                         input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        exp_t e;
        req_a = ra;
        req_b = rb;
        din_a = da;
        din_b = db;
        model_step(ra, rb, da, db);
        @(posedge clk);
        e.ga = (m_owner == 1);
        e.gb = (m_owner == 2);
        e.s  = (m_owner == 2);
        e.yv = m_yv;
        e.y  = m_y;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check({tag, "_gnt_a"},   gnt_a,   0);
        check({tag, "_gnt_b"},   gnt_b,   0);
        check({tag, "_s0"},      s0,      0);
        check({tag, "_y"},       y,       0);
        check({tag, "_y_valid"}, y_valid, 0);
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    // Monitor: scoreboard compare plus an independent burst-length watch.
    exp_t e_mon;
    int   run_side, run, side;
    logic oreq, pga, pgb, pra, prb;

    always @(negedge clk) begin
        if (rst) begin
            run_side = 0;
            run      = 0;
            pga = 1'b0; pgb = 1'b0; pra = 1'b0; prb = 1'b0;
        end else begin
            check("grant_exclusive", {31'd0, gnt_a & gnt_b}, 0);
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                check("gnt_a",   gnt_a,   e_mon.ga);
                check("gnt_b",   gnt_b,   e_mon.gb);
                check("s0",      s0,      e_mon.s);
                check("y_valid", y_valid, e_mon.yv);
                check("y",       y,       e_mon.y);
            end
            if (y_valid) begin
                side = pgb ? 2 : (pga ? 1 : 0);
                oreq = (side == 1) ? prb : pra;
                if (side != run_side) begin
                    run_side = side;
                    run      = 0;
                end
                if (oreq) begin
                    run++;
                    check("burst_len_le_max", {31'd0, run <= MH}, 1);
                end
            end else begin
                run_side = 0;
                run      = 0;
            end
            pga = gnt_a; pgb = gnt_b; pra = req_a; prb = req_b;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        din_a = '0;
        din_b = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("init_gnt_a",   gnt_a,   0);
        check("init_gnt_b",   gnt_b,   0);
        check("init_y_valid", y_valid, 0);
        check("init_y",       y,       0);
        rst = 1'b0;

        // Tie after reset: A first, preempted by B after MH beats, next tie back to A.
        cycle(1, 1, 8'hA0, 8'hB0);
        for (int i = 0; i < MH; i++) cycle(1, 1, 8'hA1 + 8'(i), 8'hB1);
        cycle(0, 1, 8'h00, 8'hB2);
        cycle(0, 1, 8'h00, 8'hB3);
        cycle(0, 0, 8'h00, 8'h00);
        cycle(1, 1, 8'hA7, 8'hB7);
        cycle(1, 1, 8'hA8, 8'hB8);
        cycle(0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00);

        // Single requester beats 11, 22, 33.
        cycle(1, 0, 8'h11, 8'h99);
        cycle(1, 0, 8'h11, 8'h99);
        cycle(1, 0, 8'h22, 8'h99);
        cycle(1, 0, 8'h33, 8'h99);
        cycle(0, 0, 8'h44, 8'h99);
        cycle(0, 0, 8'h55, 8'h99);

        // Early release by A after two beats, B waiting.
        cycle(1, 0, 8'h61, 8'h71);
        cycle(1, 1, 8'h62, 8'h72);
        cycle(1, 1, 8'h63, 8'h73);
        cycle(0, 1, 8'h64, 8'h74);
        cycle(0, 1, 8'h65, 8'h75);
        cycle(0, 1, 8'h66, 8'h76);
        cycle(0, 0, 8'h00, 8'h00);

        // Unbounded hold by B, then A arrives once the counter has saturated.
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00, 8'hC0 + 8'(i));
        cycle(1, 1, 8'hD0, 8'hCA);
        cycle(1, 1, 8'hD1, 8'hCB);
        cycle(1, 1, 8'hD2, 8'hCC);
        cycle(0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00);

        // Reset in the middle of an A burst.
        cycle(1, 0, 8'hE1, 8'h00);
        cycle(1, 0, 8'hE2, 8'h00);
        cycle(1, 0, 8'hE3, 8'h00);
        reset_mid("midreset");
        cycle(1, 1, 8'hF1, 8'hF2);
        cycle(1, 1, 8'hF3, 8'hF4);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  8'($urandom), 8'($urandom));
        end
        cycle(0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
